// File: rtl/xor_pkg.sv
// xor_pkg: shared state encoding, default sizes and saturating counter helper
package xor_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_HOLD} state_e;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v == max) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/xor_fold.sv
// xor_fold: bitwise XOR of two words plus reduction XOR of the result
module xor_fold #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             r
);
    assign y = a ^ b;
    assign r = ^y;
endmodule

// File: rtl/xor_frame_parity.sv
// xor_frame_parity: framed XOR parity accumulator with registered result handshake.
// Define XOR_PARITY_CHECK_EN to flag frames that do not fold to zero on out_err.
import xor_pkg::*;
module xor_frame_parity #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_parity,
    output logic             out_bit,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, par_q, par_d, fold_y;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_o_q, cnt_o_d, cnt_inc;
    logic             bit_q, bit_d, fold_r, fire, take;
    xor_fold #(.WIDTH(WIDTH)) u_fold (
        .a(acc_q),
        .b(in_data),
        .y(fold_y),
        .r(fold_r)
    );
    assign in_ready   = (state_q != ST_HOLD) || out_ready;
    assign out_valid  = (state_q == ST_HOLD);
    assign fire       = in_valid && in_ready;
    assign take       = out_valid && out_ready;
    assign cnt_inc    = CNT_W'(sat_inc(32'(cnt_q), 32'(CNT_MAX)));
    assign out_parity = par_q;
    assign out_bit    = bit_q;
    assign out_count  = cnt_o_q;
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        bit_d   = bit_q;
        cnt_o_d = cnt_o_q;
        if (take) state_d = ST_IDLE;
        if (fire && in_last) begin
            par_d   = fold_y;
            bit_d   = fold_r;
            cnt_o_d = cnt_inc;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_HOLD;
        end else if (fire) begin
            acc_d   = fold_y;
            cnt_d   = cnt_inc;
            state_d = ST_ACCUM;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            par_q   <= '0;
            bit_q   <= 1'b0;
            cnt_o_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            bit_q   <= bit_d;
            cnt_o_q <= cnt_o_d;
        end
    end
`ifdef XOR_PARITY_CHECK_EN
    logic err_q, err_d;
    // a frame carrying its own parity word must fold to zero
    always_comb err_d = (fire && in_last) ? (fold_y != '0) : err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif
endmodule
